// File: rtl/video_timing_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// video_timing_pkg : register map, ctrl bits, WXGA defaults, timing record
// Rev 1.0
// ============================================================================
package video_timing_pkg;

   localparam int TIMING_W = 12;

   localparam logic [3:0] ADR_V_BASE = 4'd7;
   localparam logic [3:0] ADR_CTRL   = 4'd14;
   localparam logic [3:0] ADR_VCTR   = 4'd15;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_HPOL = 1;
   localparam int CTRL_VPOL = 2;

   localparam int WXGA_H_SYNC_ON    = 72;
   localparam int WXGA_H_SYNC_OFF   = 216;
   localparam int WXGA_H_BLANK_OFF  = 434;
   localparam int WXGA_H_BORDER_OFF = 434;
   localparam int WXGA_H_BORDER_ON  = 1800;
   localparam int WXGA_H_BLANK_ON   = 1800;
   localparam int WXGA_H_TOTAL      = 1800;
   localparam int WXGA_V_SYNC_ON    = 2;
   localparam int WXGA_V_SYNC_OFF   = 5;
   localparam int WXGA_V_BLANK_OFF  = 27;
   localparam int WXGA_V_BORDER_OFF = 27;
   localparam int WXGA_V_BORDER_ON  = 795;
   localparam int WXGA_V_BLANK_ON   = 795;
   localparam int WXGA_V_TOTAL      = 795;

   // Field order matches the register offsets within each axis block.
   typedef struct packed {
      logic [TIMING_W-1:0] sync_on;
      logic [TIMING_W-1:0] sync_off;
      logic [TIMING_W-1:0] blank_off;
      logic [TIMING_W-1:0] border_off;
      logic [TIMING_W-1:0] border_on;
      logic [TIMING_W-1:0] blank_on;
      logic [TIMING_W-1:0] total;
   } timing_t;

   function automatic logic [TIMING_W-1:0] timing_get(timing_t t, logic [2:0] idx);
      case (idx)
         3'd0:    return t.sync_on;
         3'd1:    return t.sync_off;
         3'd2:    return t.blank_off;
         3'd3:    return t.border_off;
         3'd4:    return t.border_on;
         3'd5:    return t.blank_on;
         3'd6:    return t.total;
         default: return '0;
      endcase
   endfunction

   function automatic timing_t timing_set(timing_t t, logic [2:0] idx, logic [TIMING_W-1:0] val);
      timing_t r;
      r = t;
      case (idx)
         3'd0:    r.sync_on    = val;
         3'd1:    r.sync_off   = val;
         3'd2:    r.blank_off  = val;
         3'd3:    r.border_off = val;
         3'd4:    r.border_on  = val;
         3'd5:    r.blank_on   = val;
         3'd6:    r.total      = val;
         default: r = t;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// video_timing_gen_if : timing register port (write strobe, address, data)
// Rev 1.0
// ============================================================================
interface video_timing_gen_if #(
   parameter int CW = 12
) ();
   logic          we;
   logic [3:0]    adr;
   logic [CW-1:0] dat_i;
   logic [CW-1:0] dat_o;

   modport master (output we, output adr, output dat_i, input dat_o);
   modport slave  (input we, input adr, input dat_i, output dat_o);
endinterface
`default_nettype wire

// File: rtl/vtg_axis.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vtg_axis : one raster axis - position counter, active timing, raw window flags
// Rev 1.0
// ============================================================================
module vtg_axis
   import video_timing_pkg::*;
#(
   parameter int      CW  = TIMING_W,
   parameter timing_t DEF = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          ce,
   input  logic          ld,
   input  timing_t       shadow,
   output logic [CW-1:0] ctr,
   output logic          term,
   output logic          sync_raw,
   output logic          blank_raw,
   output logic          border_raw
);

   timing_t act;

   // >= rather than == so a total shrunk below the current count still wraps.
   assign term       = ctr >= CW'(act.total);
   assign sync_raw   = (ctr >= CW'(act.sync_on)) && (ctr < CW'(act.sync_off));
   assign blank_raw  = (ctr >= CW'(act.blank_on)) || (ctr < CW'(act.blank_off));
   assign border_raw = (ctr >= CW'(act.border_on)) || (ctr < CW'(act.border_off));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctr <= CW'(1);
         act <= DEF;
      end else begin
         if (ld) begin
            act <= shadow;
         end
         if (!en) begin
            ctr <= CW'(1);
         end else if (ce) begin
            ctr <= term ? CW'(1) : ctr + CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// video_timing_gen : runtime-programmable video sync generator (WXGA defaults)
// Rev 1.0
// ============================================================================
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int         CW           = TIMING_W,
   parameter int         H_SYNC_ON    = WXGA_H_SYNC_ON,
   parameter int         H_SYNC_OFF   = WXGA_H_SYNC_OFF,
   parameter int         H_BLANK_OFF  = WXGA_H_BLANK_OFF,
   parameter int         H_BORDER_OFF = WXGA_H_BORDER_OFF,
   parameter int         H_BORDER_ON  = WXGA_H_BORDER_ON,
   parameter int         H_BLANK_ON   = WXGA_H_BLANK_ON,
   parameter int         H_TOTAL      = WXGA_H_TOTAL,
   parameter int         V_SYNC_ON    = WXGA_V_SYNC_ON,
   parameter int         V_SYNC_OFF   = WXGA_V_SYNC_OFF,
   parameter int         V_BLANK_OFF  = WXGA_V_BLANK_OFF,
   parameter int         V_BORDER_OFF = WXGA_V_BORDER_OFF,
   parameter int         V_BORDER_ON  = WXGA_V_BORDER_ON,
   parameter int         V_BLANK_ON   = WXGA_V_BLANK_ON,
   parameter int         V_TOTAL      = WXGA_V_TOTAL,
   parameter logic [2:0] CTRL_RST     = 3'b101
) (
   input  logic                clk,
   input  logic                rst,
   video_timing_gen_if.slave   bus,
   output logic                hSync,
   output logic                vSync,
   output logic                blank,
   output logic                border,
   output logic                de,
   output logic [CW-1:0]       hCtr,
   output logic [CW-1:0]       vCtr,
   output logic                vbl_irq
);

   localparam timing_t H_DEF = '{
      sync_on:    TIMING_W'(H_SYNC_ON),
      sync_off:   TIMING_W'(H_SYNC_OFF),
      blank_off:  TIMING_W'(H_BLANK_OFF),
      border_off: TIMING_W'(H_BORDER_OFF),
      border_on:  TIMING_W'(H_BORDER_ON),
      blank_on:   TIMING_W'(H_BLANK_ON),
      total:      TIMING_W'(H_TOTAL)
   };
   localparam timing_t V_DEF = '{
      sync_on:    TIMING_W'(V_SYNC_ON),
      sync_off:   TIMING_W'(V_SYNC_OFF),
      blank_off:  TIMING_W'(V_BLANK_OFF),
      border_off: TIMING_W'(V_BORDER_OFF),
      border_on:  TIMING_W'(V_BORDER_ON),
      blank_on:   TIMING_W'(V_BLANK_ON),
      total:      TIMING_W'(V_TOTAL)
   };

   timing_t             sh_h;
   timing_t             sh_v;
   logic [2:0]          ctrl;
   logic                en;
   logic                eol;
   logic                eof;
   logic                load;
   logic                h_term, h_sync, h_blank, h_border;
   logic                v_term, v_sync, v_blank, v_border;
   logic                vblank_q;
   logic [2:0]          v_idx;
   logic [TIMING_W-1:0] wdat;

   assign en    = ctrl[CTRL_EN];
   assign eol   = en & h_term;
   assign eof   = eol & v_term;
   // While disabled the actives track the shadows so a re-enable starts clean.
   assign load  = ~en | eof;
   assign v_idx = 3'(bus.adr - ADR_V_BASE);
   assign wdat  = TIMING_W'(bus.dat_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_h <= H_DEF;
         sh_v <= V_DEF;
         ctrl <= CTRL_RST;
      end else if (bus.we) begin
         if (bus.adr < ADR_V_BASE) begin
            sh_h <= timing_set(sh_h, bus.adr[2:0], wdat);
         end else if (bus.adr < ADR_CTRL) begin
            sh_v <= timing_set(sh_v, v_idx, wdat);
         end else if (bus.adr == ADR_CTRL) begin
            ctrl <= bus.dat_i[2:0];
         end
      end
   end

   always_comb begin
      bus.dat_o = '0;
      if (bus.adr < ADR_V_BASE) begin
         bus.dat_o = CW'(timing_get(sh_h, bus.adr[2:0]));
      end else if (bus.adr < ADR_CTRL) begin
         bus.dat_o = CW'(timing_get(sh_v, v_idx));
      end else if (bus.adr == ADR_CTRL) begin
         bus.dat_o = CW'(ctrl);
      end else if (bus.adr == ADR_VCTR) begin
         bus.dat_o = vCtr;
      end
   end

   vtg_axis #(.CW(CW), .DEF(H_DEF)) u_h_axis (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .ce         (1'b1),
      .ld         (load),
      .shadow     (sh_h),
      .ctr        (hCtr),
      .term       (h_term),
      .sync_raw   (h_sync),
      .blank_raw  (h_blank),
      .border_raw (h_border)
   );

   vtg_axis #(.CW(CW), .DEF(V_DEF)) u_v_axis (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .ce         (eol),
      .ld         (load),
      .shadow     (sh_v),
      .ctr        (vCtr),
      .term       (v_term),
      .sync_raw   (v_sync),
      .blank_raw  (v_blank),
      .border_raw (v_border)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank    <= 1'b1;
         border   <= 1'b1;
         de       <= 1'b0;
         hSync    <= ~CTRL_RST[CTRL_HPOL];
         vSync    <= ~CTRL_RST[CTRL_VPOL];
         vblank_q <= 1'b1;
         vbl_irq  <= 1'b0;
      end else begin
         blank    <= ~en | h_blank | v_blank;
         border   <= ~en | h_border | v_border;
         de       <= en & ~h_border & ~v_border;
         hSync    <= ~((en & h_sync) ^ ctrl[CTRL_HPOL]);
         vSync    <= ~((en & v_sync) ^ ctrl[CTRL_VPOL]);
         vblank_q <= ~en | v_blank;
         vbl_irq  <= en & v_blank & ~vblank_q;
      end
   end

endmodule
`default_nettype wire
